// File: rtl/timer_ctl_if.sv
// Register/tick/interrupt bundle for timer_ctl. The slave modport is the timer
// side and the master modport is the CPU/test side. dbg_state mirrors the FSM.
interface timer_ctl_if #(parameter int WIDTH = 16);
  logic             WR;
  logic [1:0]       ADDR;
  logic [WIDTH-1:0] DIN;
  logic [WIDTH-1:0] DOUT;
  logic             TICK;
  logic             IACK;
  logic [WIDTH-1:0] CNT;
  logic             TC;
  logic             IRQ;
  logic [1:0]       dbg_state;

  // WR is a single-cycle strobe with no back-pressure: every cycle that has
  // WR=1 is one accepted write, committed at the edge that samples it.
  modport slave (
    input  WR, ADDR, DIN, TICK, IACK,
    output DOUT, CNT, TC, IRQ, dbg_state
  );

  modport master (
    output WR, ADDR, DIN, TICK, IACK,
    input  DOUT, CNT, TC, IRQ, dbg_state
  );
endinterface

// File: rtl/timer_ctl.sv
// Interval timer sequencer: reload/control registers, load/run/done FSM, terminal
// count and level IRQ. Define TIMCTL_PRESCALE_EN to add the 4-bit tick prescaler.
module timer_ctl #(
  parameter int WIDTH = 16
) (
  input  logic        MasterClock,
  input  logic        RESET,
  timer_ctl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reload_q;
  logic [7:0]       ctrl_q;
  logic [7:0]       ctrl_wdata;
  logic [WIDTH-1:0] cnt_q;
  logic             tc_q;
  logic             irq_q;

  logic reload_wr, ctrl_wr, irq_clr_wr;
  logic run_active, qtick, count_en, wrap, do_load;

  assign reload_wr  = bus.WR && (bus.ADDR == 2'd0);
  assign ctrl_wr    = bus.WR && (bus.ADDR == 2'd1);
  assign irq_clr_wr = bus.WR && (bus.ADDR == 2'd2);

  // A control write in RUN restarts or stops the timer, so it suppresses counting.
  assign run_active = (state_q == S_RUN) && !ctrl_wr;

`ifdef TIMCTL_PRESCALE_EN
  logic [3:0] presc_q;

  assign ctrl_wdata = {bus.DIN[7:4], 1'b0, bus.DIN[2:0]};
  assign qtick      = bus.TICK && (presc_q == ctrl_q[7:4]);

  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      presc_q <= 4'd0;
    end else if (state_q == S_LOAD) begin
      presc_q <= 4'd0;
    end else if (run_active && bus.TICK) begin
      presc_q <= qtick ? 4'd0 : presc_q + 4'd1;
    end
  end
`else
  assign ctrl_wdata = {5'd0, bus.DIN[2:0]};
  assign qtick      = bus.TICK;
`endif

  assign count_en = run_active && qtick;
  assign wrap     = count_en && (cnt_q == {WIDTH{1'b1}});
  assign do_load  = (state_q == S_LOAD) && (state_d == S_RUN);

  always_comb begin
    state_d = state_q;
    if (ctrl_wr) begin
      state_d = bus.DIN[0] ? S_LOAD : S_IDLE;
    end else if (!ctrl_q[0]) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_LOAD;
        S_LOAD:  state_d = S_RUN;
        S_RUN:   state_d = (wrap && ctrl_q[1]) ? S_DONE : S_RUN;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      reload_q <= '0;
      ctrl_q   <= 8'd0;
      cnt_q    <= '0;
      tc_q     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (reload_wr) reload_q <= bus.DIN;
      if (ctrl_wr)   ctrl_q   <= ctrl_wdata;

      // Load/reload always uses the reload value held before this edge.
      if (do_load) begin
        cnt_q <= reload_q;
      end else if (wrap) begin
        cnt_q <= ctrl_q[1] ? '0 : reload_q;
      end else if (count_en) begin
        cnt_q <= cnt_q + 1'b1;
      end

      tc_q <= wrap;

      // Set beats clear when both land in the same cycle.
      if (wrap && ctrl_q[2]) begin
        irq_q <= 1'b1;
      end else if (bus.IACK || irq_clr_wr) begin
        irq_q <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.DOUT = '0;
    case (bus.ADDR)
      2'd0:    bus.DOUT = reload_q;
      2'd1:    bus.DOUT = {{(WIDTH-8){1'b0}}, ctrl_q};
      2'd2:    bus.DOUT = {{(WIDTH-3){1'b0}}, irq_q, state_q};
      default: bus.DOUT = cnt_q;
    endcase
  end

  assign bus.CNT       = cnt_q;
  assign bus.TC        = tc_q;
  assign bus.IRQ       = irq_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_timer_ctl.sv
// Directed bench for timer_ctl: reset, continuous, one-shot, IRQ set/clear race,
// mid-run register changes and the prescaler (per TIMCTL_PRESCALE_EN).
module tb_timer_ctl;
  localparam int WIDTH = 16;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  timer_ctl_if #(.WIDTH(WIDTH)) bus ();

  timer_ctl #(.WIDTH(WIDTH)) dut (
    .MasterClock (clk),
    .RESET       (rst),
    .bus         (bus.slave)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [WIDTH-1:0] data);
    bus.WR   = 1'b1;
    bus.ADDR = addr;
    bus.DIN  = data;
    step();
    bus.WR   = 1'b0;
    bus.DIN  = '0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    bus.ADDR = addr;
    #1;
    check(tag, 32'(bus.DOUT), exp);
  endtask

  logic [WIDTH-1:0] exp_cnt[6];
  logic             exp_tc[6];

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    bus.WR   = 1'b0;
    bus.ADDR = 2'd0;
    bus.DIN  = '0;
    bus.TICK = 1'b0;
    bus.IACK = 1'b0;
    step();
    step();
    rst = 1'b0;

    // reset state
    check("rst_cnt", 32'(bus.CNT), 32'h0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    check("rst_tc", 32'(bus.TC), 32'd0);
    check("rst_irq", 32'(bus.IRQ), 32'd0);
    rd_check("rst_reload", 2'd0, 32'h0);
    rd_check("rst_ctrl", 2'd1, 32'h0);

    // reset mid-run
    wr(2'd0, 16'h1234);
    wr(2'd1, 16'h0001);
    check("start_load_state", 32'(bus.dbg_state), 32'd1);
    step();
    check("start_cnt", 32'(bus.CNT), 32'h1234);
    check("start_run_state", 32'(bus.dbg_state), 32'd2);
    bus.TICK = 1'b1;
    repeat (3) step();
    check("run_cnt", 32'(bus.CNT), 32'h1237);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.TICK = 1'b0;
    check("midrst_cnt", 32'(bus.CNT), 32'h0);
    check("midrst_state", 32'(bus.dbg_state), 32'd0);
    check("midrst_irq", 32'(bus.IRQ), 32'd0);
    check("midrst_tc", 32'(bus.TC), 32'd0);
    rd_check("midrst_ctrl", 2'd1, 32'h0);

    // continuous mode, IRQ enabled; TICK during LOAD must be ignored
    wr(2'd0, 16'hFFFD);
    wr(2'd1, 16'h0005);
    bus.TICK = 1'b1;
    step();
    check("cont_load_cnt", 32'(bus.CNT), 32'hFFFD);
    check("cont_load_irq", 32'(bus.IRQ), 32'd0);
    exp_cnt = '{16'hFFFE, 16'hFFFF, 16'hFFFD, 16'hFFFE, 16'hFFFF, 16'hFFFD};
    exp_tc  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("cont_cnt_%0d", i), 32'(bus.CNT), 32'(exp_cnt[i]));
      check($sformatf("cont_tc_%0d", i), 32'(bus.TC), 32'(exp_tc[i]));
      check($sformatf("cont_irq_%0d", i), 32'(bus.IRQ), (i >= 2) ? 32'd1 : 32'd0);
    end
    bus.TICK = 1'b0;
    bus.IACK = 1'b1;
    step();
    bus.IACK = 1'b0;
    check("cont_iack_irq", 32'(bus.IRQ), 32'd0);
    check("cont_iack_tc", 32'(bus.TC), 32'd0);
    check("cont_hold_cnt", 32'(bus.CNT), 32'hFFFD);

    // one-shot mode
    wr(2'd1, 16'h0000);
    check("os_idle", 32'(bus.dbg_state), 32'd0);
    wr(2'd0, 16'hFFFE);
    wr(2'd1, 16'h0007);
    bus.TICK = 1'b1;
    step();
    check("os_load_cnt", 32'(bus.CNT), 32'hFFFE);
    step();
    check("os_cnt1", 32'(bus.CNT), 32'hFFFF);
    check("os_tc1", 32'(bus.TC), 32'd0);
    step();
    check("os_wrap_cnt", 32'(bus.CNT), 32'h0);
    check("os_wrap_tc", 32'(bus.TC), 32'd1);
    check("os_wrap_state", 32'(bus.dbg_state), 32'd3);
    check("os_wrap_irq", 32'(bus.IRQ), 32'd1);
    repeat (2) step();
    check("os_done_cnt", 32'(bus.CNT), 32'h0);
    check("os_done_tc", 32'(bus.TC), 32'd0);
    check("os_done_state", 32'(bus.dbg_state), 32'd3);
    rd_check("os_status", 2'd2, 32'h7);
    wr(2'd1, 16'h0007);
    check("os_retrig_state", 32'(bus.dbg_state), 32'd1);
    step();
    check("os_retrig_cnt", 32'(bus.CNT), 32'hFFFE);
    step();
    check("os_retrig_tc0", 32'(bus.TC), 32'd0);
    step();
    check("os_retrig_tc1", 32'(bus.TC), 32'd1);
    check("os_retrig_done", 32'(bus.dbg_state), 32'd3);
    bus.TICK = 1'b0;
    wr(2'd2, 16'h0000);
    check("os_wrclr_irq", 32'(bus.IRQ), 32'd0);

    // IRQ set and IACK in the same cycle: set wins
    wr(2'd1, 16'h0000);
    wr(2'd0, 16'hFFFE);
    wr(2'd1, 16'h0005);
    bus.TICK = 1'b1;
    step();
    step();
    check("race_pre_cnt", 32'(bus.CNT), 32'hFFFF);
    bus.IACK = 1'b1;
    step();
    bus.IACK = 1'b0;
    bus.TICK = 1'b0;
    check("race_tc", 32'(bus.TC), 32'd1);
    check("race_irq", 32'(bus.IRQ), 32'd1);
    bus.IACK = 1'b1;
    step();
    bus.IACK = 1'b0;
    check("race_clr_irq", 32'(bus.IRQ), 32'd0);

    // mid-run reload change, then stop
    wr(2'd1, 16'h0000);
    wr(2'd0, 16'hFFFC);
    wr(2'd1, 16'h0001);
    step();
    bus.TICK = 1'b1;
    step();
    bus.TICK = 1'b0;
    check("mid_cnt0", 32'(bus.CNT), 32'hFFFD);
    wr(2'd0, 16'hFFF0);
    check("mid_reload_nodisturb", 32'(bus.CNT), 32'hFFFD);
    rd_check("mid_reload_rd", 2'd0, 32'hFFF0);
    bus.TICK = 1'b1;
    step();
    step();
    step();
    check("mid_wrap_cnt", 32'(bus.CNT), 32'hFFF0);
    check("mid_wrap_tc", 32'(bus.TC), 32'd1);
    check("mid_wrap_noirq", 32'(bus.IRQ), 32'd0);
    step();
    check("mid_cnt_after", 32'(bus.CNT), 32'hFFF1);
    bus.TICK = 1'b0;
    wr(2'd1, 16'h0000);
    check("stop_state", 32'(bus.dbg_state), 32'd0);
    bus.TICK = 1'b1;
    repeat (2) step();
    bus.TICK = 1'b0;
    check("stop_cnt_frozen", 32'(bus.CNT), 32'hFFF1);
    rd_check("live_count_rd", 2'd3, 32'hFFF1);

    // prescaler: PRESCALE=3 qualifies every 4th tick when built in
    wr(2'd0, 16'hFFFF);
    wr(2'd1, 16'h0031);
    bus.TICK = 1'b1;
    step();
    check("psc_load_cnt", 32'(bus.CNT), 32'hFFFF);
    for (int i = 0; i < 8; i++) begin
      step();
`ifdef TIMCTL_PRESCALE_EN
      check($sformatf("psc_tc_%0d", i), 32'(bus.TC), (i % 4 == 3) ? 32'd1 : 32'd0);
`else
      check($sformatf("psc_tc_%0d", i), 32'(bus.TC), 32'd1);
`endif
    end
    bus.TICK = 1'b0;
`ifdef TIMCTL_PRESCALE_EN
    rd_check("psc_ctrl_rd", 2'd1, 32'h31);
`else
    rd_check("psc_ctrl_rd", 2'd1, 32'h01);
`endif
    wr(2'd3, 16'hABCD);
    rd_check("reserved_nowrite_reload", 2'd0, 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
